// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS PC path.
//   pc_state_e        : PC unit FSM states
//   DEF_*_VECTOR      : default reset and trap targets
//   PC_SEL_*          : next-PC source indices used by the control unit
package mips_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  localparam int unsigned PC_SEL_MEM     = 0;
  localparam int unsigned PC_SEL_RESULT  = 1;
  localparam int unsigned PC_SEL_ALU_OUT = 2;
  localparam int unsigned PC_SEL_PC      = 3;
  localparam int unsigned PC_SEL_LS      = 4;
  localparam int unsigned PC_SEL_EPC     = 5;
  localparam int unsigned PC_SEL_CONCAT  = 6;

endpackage

// File: rtl/pc_update_unit_if.sv
// Control-unit <-> PC-unit bus.
//   master : control side, drives sel/src_data/pc_write/stall/exc_req
//   slave  : PC unit, drives pc/epc/bad_addr/trap_taken/sel_err/in_trap
interface pc_update_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 7,
  parameter int unsigned SEL_W   = 3
);

  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     pc_write;
  logic                     stall;
  logic                     exc_req;
  logic [WIDTH-1:0]         pc;
  logic [WIDTH-1:0]         epc;
  logic [WIDTH-1:0]         bad_addr;
  logic                     trap_taken;
  logic                     sel_err;
  logic                     in_trap;

  modport master (
    output sel, src_data, pc_write, stall, exc_req,
    input  pc, epc, bad_addr, trap_taken, sel_err, in_trap
  );

  modport slave (
    input  sel, src_data, pc_write, stall, exc_req,
    output pc, epc, bad_addr, trap_taken, sel_err, in_trap
  );

endinterface

// File: rtl/pc_src_mux.sv
// Combinational next-PC source selector.
//   i_sel          : source index
//   i_src_data     : flattened sources, source i at [i*WIDTH +: WIDTH]
//   o_data_c       : selected source (zero when i_sel is out of range)
//   o_sel_valid_c  : i_sel < NUM_SRC
module pc_src_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 7,
  parameter int unsigned SEL_W   = 3
) (
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [NUM_SRC*WIDTH-1:0] i_src_data,
  output logic [WIDTH-1:0]         o_data_c,
  output logic                     o_sel_valid_c
);

  // Defaults cover every out-of-range index, so nothing is ever latched or X.
  always_comb begin
    o_data_c      = '0;
    o_sel_valid_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_data_c      = i_src_data[i*WIDTH +: WIDTH];
        o_sel_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// Registered program counter with source selection, alignment/range
// checking and trap entry to a fixed vector.
//   clk   : core clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of pc_update_unit_if (sel/src_data/pc_write/stall/
//           exc_req in; pc/epc/bad_addr/trap_taken/sel_err/in_trap out)
module pc_update_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      NUM_SRC      = 7,
  parameter int unsigned      SEL_W        = 3,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter bit               ALIGN_CHECK  = 1'b1
) (
  input logic              clk,
  input logic              reset,
  pc_update_unit_if.slave  bus
);

  pc_state_e        r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_bad_addr;
  logic             r_trap_taken;
  logic             r_sel_err;
  logic             r_in_trap;

  logic [WIDTH-1:0] w_src;
  logic             w_sel_valid;
  logic             w_load;
  logic             w_misaligned;

  pc_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .i_sel         (bus.sel),
    .i_src_data    (bus.src_data),
    .o_data_c      (w_src),
    .o_sel_valid_c (w_sel_valid)
  );

  assign w_load       = bus.pc_write && !bus.stall;
  assign w_misaligned = ALIGN_CHECK && (w_src[1:0] != 2'b00);

  // PC state machine; pulses default low each cycle and are set only on events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_bad_addr   <= '0;
      r_trap_taken <= 1'b0;
      r_sel_err    <= 1'b0;
      r_in_trap    <= 1'b0;
    end else begin
      r_trap_taken <= 1'b0;
      r_sel_err    <= 1'b0;
      case (r_state)
        RUN: begin
          if (bus.exc_req) begin
            r_pc         <= EXC_VECTOR;
            r_epc        <= r_pc;
            r_trap_taken <= 1'b1;
            r_in_trap    <= 1'b1;
            r_state      <= TRAP;
          end else if (w_load && w_sel_valid && w_misaligned) begin
            r_pc         <= EXC_VECTOR;
            r_epc        <= r_pc;
            r_bad_addr   <= w_src;
            r_trap_taken <= 1'b1;
            r_in_trap    <= 1'b1;
            r_state      <= TRAP;
          end else if (w_load && !w_sel_valid) begin
            r_sel_err <= 1'b1;
          end else if (w_load) begin
            r_pc <= w_src;
          end
        end
        TRAP: begin
          // Load requests are dropped here; only a new exception is honoured.
          r_pc <= EXC_VECTOR;
          if (bus.exc_req) begin
            r_epc        <= r_pc;
            r_trap_taken <= 1'b1;
          end else begin
            r_in_trap <= 1'b0;
            r_state   <= RUN;
          end
        end
        default: begin
          r_in_trap <= 1'b0;
          r_state   <= RUN;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.epc        = r_epc;
  assign bus.bad_addr   = r_bad_addr;
  assign bus.trap_taken = r_trap_taken;
  assign bus.sel_err    = r_sel_err;
  assign bus.in_trap    = r_in_trap;

endmodule
